// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared sizes, types and pointer helper for the FIFO drain controller
package fifo_drain_pkg;
    localparam int BUF_DEPTH = 3;
    typedef logic [1:0] buf_ptr_t;
    typedef logic [1:0] buf_cnt_t;
    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO read port plus valid/ready output stream of the drain controller
interface fifo_drain_if #(parameter int WIDTH = 16);
    logic             fifo_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    modport master(input fifo_empty, fifo_data_out, out_ready, output fifo_read, out_data, out_valid, out_last);
    modport slave(output fifo_empty, fifo_data_out, out_ready, input fifo_read, out_data, out_valid, out_last);
endinterface

// File: rtl/fifo_drain_buf.sv
// drain_buf: 3-entry circular skid store absorbing FIFO read latency under backpressure
module drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output buf_cnt_t         cnt
);
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    buf_ptr_t head, tail;
    assign rd_data = mem[head];
    // storage, pointers and occupancy; simultaneous push and pop leave cnt unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            cnt <= cnt + buf_cnt_t'(push) - buf_cnt_t'(pop);
        end
    end
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: drains a registered-read FIFO into a packetised valid/ready stream
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PKT_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         drain_en,
    output logic [7:0]   pkt_cnt,
    fifo_drain_if.master bus
);
    logic     infl;
    logic     pop;
    logic     at_last;
    logic [7:0] widx;
    buf_cnt_t buf_cnt;
    assign bus.fifo_read = !rst && drain_en && !bus.fifo_empty && (3'(buf_cnt) + 3'(infl) < 3'(BUF_DEPTH));
    assign bus.out_valid = buf_cnt != '0;
    assign pop           = bus.out_valid && bus.out_ready;
    assign at_last       = widx == 8'(PKT_LEN - 1);
    assign bus.out_last  = bus.out_valid && at_last;
    drain_buf #(.WIDTH(WIDTH)) u_buf (
        .clk(clk),
        .rst(rst),
        .push(infl),
        .push_data(bus.fifo_data_out),
        .pop(pop),
        .rd_data(bus.out_data),
        .cnt(buf_cnt)
    );
    // in-flight read flag, word-in-packet index and completed packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            infl    <= 1'b0;
            widx    <= '0;
            pkt_cnt <= '0;
        end else begin
            infl <= bus.fifo_read;
            if (pop) widx <= at_last ? '0 : widx + 8'd1;
            if (pop && at_last) pkt_cnt <= pkt_cnt + 8'd1;
        end
    end
endmodule
